// File: rtl/regfile_write_arbiter.sv
// Shared write-port controller for the 32x32 register file, with a pending-write scoreboard.
// Optional RFARB_RR_EN selects round-robin arbitration; undefined gives fixed priority (lowest index).
`timescale 1ns/1ps
module regfile_write_arbiter #(
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [5*NREQ-1:0]  req_rd,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [4:0]         rf_a3,
  output logic [31:0]        rf_wd3,
  output logic               rf_we,
  input  logic               rsv_valid,
  input  logic [4:0]         rsv_rd,
  input  logic [4:0]         q_rs1,
  input  logic [4:0]         q_rs2,
  output logic               q_busy1,
  output logic               q_busy2
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_ARB = 1'b0, ST_WR = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [4:0]     r_a3;
  logic [31:0]    r_wd3;
  logic [31:0]    r_busy;
  logic [31:0]    w_busy_next;
  logic           w_found;
  logic [PW-1:0]  w_grant_idx;
  logic [4:0]     w_sel_rd;
  logic [31:0]    w_sel_data;

`ifdef RFARB_RR_EN
  // r_ptr holds the last granted index; the search starts just after it.
  logic [PW-1:0] r_ptr;

  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found     = 1'b1;
        w_grant_idx = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_ptr <= PW'(NREQ - 1);
    end else if (r_state == ST_ARB && w_found) begin
      r_ptr <= w_grant_idx;
    end
  end
`else
  always_comb begin
    w_found     = |req_valid;
    w_grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_grant_idx = PW'(k);
      end
    end
  end
`endif

  assign w_sel_rd   = req_rd[int'(w_grant_idx) * 5 +: 5];
  assign w_sel_data = req_data[int'(w_grant_idx) * 32 +: 32];

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= ST_ARB;
      r_a3    <= '0;
      r_wd3   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_ARB && w_found) begin
        r_a3  <= w_sel_rd;
        r_wd3 <= w_sel_data;
      end
    end
  end

  // WR always returns to ARB, so WE3 can never be high on consecutive cycles.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    rf_we        = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_found && !resetn) begin
          req_ready    = NREQ'(1) << w_grant_idx;
          w_state_next = ST_WR;
        end
      end
      ST_WR: begin
        rf_we        = (r_a3 != 5'd0);
        w_state_next = ST_ARB;
      end
      default: w_state_next = ST_ARB;
    endcase
  end

  assign rf_a3  = r_a3;
  assign rf_wd3 = r_wd3;

  // Set is applied after clear so a newer producer reserving the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_state == ST_WR) begin
      w_busy_next[r_a3] = 1'b0;
    end
    if (rsv_valid) begin
      w_busy_next[rsv_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign q_busy1 = r_busy[q_rs1];
  assign q_busy2 = r_busy[q_rs2];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table plus hand sequences for contention,
// scoreboard set/clear ordering and asynchronous reset during a write.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we;
  logic        rsv_valid;
  logic [4:0]  rsv_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_busy1;
  logic        q_busy2;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we(rf_we),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [95:0] data;
    int          exp_fp;
    int          exp_rr;
  } vec_t;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we;
  } wr_t;

  vec_t        vecs[8];
  wr_t         sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          seq[4];
  logic [4:0]  last_a3;
  logic [31:0] last_wd3;

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input int fp, input int rr);
    vec_t t;
    t.valid  = v;
    t.rd     = {r2, r1, r0};
    t.data   = {d2, d1, d0};
    t.exp_fp = fp;
    t.exp_rr = rr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ARB cycle: grant must match the model; latched outputs must still hold the previous write.
  task automatic arb_cycle(input int exp_idx);
    logic [2:0] exp_rdy;
    wr_t        w;
    @(negedge clk);
    exp_rdy = (exp_idx < 0) ? 3'b000 : 3'(1 << exp_idx);
    check("arb_ready", 32'(req_ready), 32'(exp_rdy));
    check("arb_we_low", 32'(rf_we), 32'd0);
    check("arb_a3_hold", 32'(rf_a3), 32'(last_a3));
    check("arb_wd3_hold", rf_wd3, last_wd3);
    if (exp_idx >= 0) begin
      w.a3  = req_rd[5*exp_idx +: 5];
      w.wd3 = req_data[32*exp_idx +: 32];
      w.we  = (w.a3 != 5'd0);
      sb_q.push_back(w);
    end
  endtask

  task automatic wr_check();
    wr_t w;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL wr_queue: got empty expected pending write");
    end else begin
      w = sb_q.pop_front();
      check("wr_we", 32'(rf_we), 32'(w.we));
      check("wr_a3", 32'(rf_a3), 32'(w.a3));
      check("wr_wd3", rf_wd3, w.wd3);
      check("wr_ready_low", 32'(req_ready), 32'd0);
      last_a3  = w.a3;
      last_wd3 = w.wd3;
      $display("txn write a3=%0d wd3=%h we=%0d", w.a3, w.wd3, w.we);
    end
  endtask

  initial begin
    wr_t w;
    vecs[0] = mk(3'b001, 5'd5,  5'd3,  5'd4,  32'hDEADBEEF, 32'h11111111, 32'h22222222, 0, 0);
    vecs[1] = mk(3'b000, 5'd5,  5'd3,  5'd4,  32'hDEADBEEF, 32'h11111111, 32'h22222222, -1, -1);
    vecs[2] = mk(3'b110, 5'd5,  5'd6,  5'd8,  32'h00000001, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 1);
    vecs[3] = mk(3'b011, 5'd10, 5'd11, 5'd12, 32'h0000000A, 32'h0000000B, 32'h0000000C, 0, 0);
    vecs[4] = mk(3'b010, 5'd19, 5'd0,  5'd20, 32'h00000013, 32'h00001234, 32'h00000014, 1, 1);
    vecs[5] = mk(3'b101, 5'd13, 5'd14, 5'd15, 32'h0000000D, 32'h0000000E, 32'h0000000F, 0, 2);
    vecs[6] = mk(3'b111, 5'd16, 5'd17, 5'd18, 32'h00000010, 32'h00000011, 32'h00000012, 0, 0);
    vecs[7] = mk(3'b100, 5'd1,  5'd2,  5'd31, 32'h00000021, 32'h00000022, 32'hFFFFFFFF, 2, 2);

    resetn    = 1'b1;
    req_valid = 3'b111;
    req_rd    = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_rd    = '0;
    q_rs1     = 5'd7;
    q_rs2     = 5'd9;
    last_a3   = '0;
    last_wd3  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_a3", 32'(rf_a3), 32'd0);
    check("rst_wd3", rf_wd3, 32'd0);
    check("rst_busy1", 32'(q_busy1), 32'd0);
    @(posedge clk);
    #1;
    resetn    = 1'b0;
    req_valid = '0;

    for (int i = 0; i < 8; i++) begin
      int e;
      next_cycle();
      req_valid = vecs[i].valid;
      req_rd    = vecs[i].rd;
      req_data  = vecs[i].data;
`ifdef RFARB_RR_EN
      e = vecs[i].exp_rr;
`else
      e = vecs[i].exp_fp;
`endif
      arb_cycle(e);
      if (e >= 0) begin
        next_cycle();
        req_valid = '0;
        wr_check();
      end
    end

`ifdef RFARB_RR_EN
    seq = '{0, 1, 2, 0};
`else
    seq = '{0, 0, 0, 0};
`endif
    next_cycle();
`ifdef RFARB_RR_EN
    req_valid = 3'b111;
`else
    req_valid = 3'b101;
`endif
    req_rd   = {5'd3, 5'd2, 5'd1};
    req_data = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      arb_cycle(seq[i]);
      next_cycle();
      wr_check();
    end

    next_cycle();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_rd    = 5'd7;
    @(negedge clk);
    check("busy_before_set", 32'(q_busy1), 32'd0);
    next_cycle();
    rsv_rd = 5'd9;
    @(negedge clk);
    check("busy_set7", 32'(q_busy1), 32'd1);
    check("busy9_not_yet", 32'(q_busy2), 32'd0);
    next_cycle();
    rsv_rd = 5'd0;
    @(negedge clk);
    check("busy_keep7", 32'(q_busy1), 32'd1);
    check("busy_set9", 32'(q_busy2), 32'd1);
    next_cycle();
    rsv_valid = 1'b0;
    q_rs2     = 5'd0;
    @(negedge clk);
    check("busy_x0", 32'(q_busy2), 32'd0);

    next_cycle();
    q_rs2     = 5'd9;
    req_valid = 3'b001;
    req_rd    = {5'd3, 5'd2, 5'd7};
    req_data  = {32'hCCCC0003, 32'hBBBB0002, 32'h00000077};
    arb_cycle(0);
    check("busy_at_accept", 32'(q_busy1), 32'd1);
    next_cycle();
    req_valid = '0;
    wr_check();
    check("busy_in_wr", 32'(q_busy1), 32'd1);
    next_cycle();
    rsv_valid = 1'b1;
    rsv_rd    = 5'd7;
    @(negedge clk);
    check("busy_clear", 32'(q_busy1), 32'd0);

    next_cycle();
    rsv_valid = 1'b0;
    req_valid = 3'b001;
    req_data  = {32'hCCCC0003, 32'hBBBB0002, 32'h00007777};
    arb_cycle(0);
    check("busy_reset7", 32'(q_busy1), 32'd1);
    next_cycle();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_rd    = 5'd7;
    wr_check();
    next_cycle();
    rsv_valid = 1'b0;
    @(negedge clk);
    check("busy_set_wins", 32'(q_busy1), 32'd1);
    check("busy9_kept", 32'(q_busy2), 32'd1);

    next_cycle();
    req_valid = 3'b100;
    req_rd    = {5'd12, 5'd2, 5'd1};
    req_data  = {32'hC0FFEE00, 32'hBBBB0002, 32'hAAAA0001};
    arb_cycle(2);
    next_cycle();
    req_valid = 3'b111;
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL mid_queue: got empty expected pending write");
    end else begin
      w = sb_q.pop_front();
      check("mid_we", 32'(rf_we), 32'(w.we));
      check("mid_a3", 32'(rf_a3), 32'(w.a3));
      $display("txn write a3=%0d wd3=%h we=%0d (interrupted)", w.a3, w.wd3, w.we);
    end
    check("mid_busy1", 32'(q_busy1), 32'd1);
    resetn = 1'b1;
    #1;
    check("async_we", 32'(rf_we), 32'd0);
    check("async_a3", 32'(rf_a3), 32'd0);
    check("async_wd3", rf_wd3, 32'd0);
    check("async_busy1", 32'(q_busy1), 32'd0);
    check("async_busy2", 32'(q_busy2), 32'd0);
    check("async_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_hold_ready", 32'(req_ready), 32'd0);
    check("rst_hold_we", 32'(rf_we), 32'd0);

    next_cycle();
    resetn    = 1'b0;
    last_a3   = '0;
    last_wd3  = '0;
    req_valid = 3'b111;
    req_rd    = {5'd12, 5'd22, 5'd21};
    req_data  = {32'h0000000C, 32'h00000016, 32'h00000015};
    arb_cycle(0);
    next_cycle();
    req_valid = '0;
    wr_check();

    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
